move_sequencer: RTL
===================

// Module: move_sequencer
// PURPOSE
//  Game-flow controller for the Connect-4 datapath. Accepts a player's column
//  choice, validates it against per-column fill heights, animates the falling
//  piece row by row, issues one board write, and samples the external win
//  checker. It then toggles the turn (01 <-> 10) or ends the game on a win or a
//  full board. Sits between the input decoder and the board RAM / VGA renderer.
// PARAMETERS
//  COLS        7   board columns (<= 8)
//  ROWS        6   board rows (<= 8); row 0 = bottom
//  DROP_TICKS  4   clock cycles the falling piece is shown at each row (>= 1)
// PORTS
//  clock       in   1  system clock; all logic on posedge
//  reset       in   1  synchronous, active-high; returns every register to reset value
//  place       in   1  1-cycle request to drop a piece in `column`
//  column      in   3  requested column, 0..COLS-1
//  win         in   1  win-checker result, valid in the cycle after wr_en
//  ready       out  1  1 in IDLE only; place is accepted only when ready=1
//  reject      out  1  1-cycle pulse: place refused (column full or column >= COLS)
//  turn        out  2  current player colour: 2'b01 or 2'b10
//  anim_valid  out  1  1 while in DROP
//  anim_row    out  3  row currently showing the falling piece
//  anim_col    out  3  column of the falling piece
//  wr_en       out  1  1-cycle board write strobe
//  wr_row      out  3  row written
//  wr_col      out  3  column written
//  wr_colour   out  2  colour written (= turn)
//  game_over   out  1  sticky until reset
//  winner      out  2  2'b00 none/draw, else winning colour
//  draw        out  1  sticky: board filled with no win
// BEHAVIOUR
//  Reset values: FSM=IDLE, turn=2'b01, all heights=0, move_count=0; all
//   outputs 0 except ready=1 and turn=01.
//  States: IDLE -> DROP -> WRITE -> CHECK -> IDLE | OVER.
//  IDLE: on place with column<COLS and height[column]<ROWS, latch col and
//   target row r=height[column]. Next cycle enter DROP with anim_row=ROWS-1.
//   On place with an invalid or full column, reject=1 next cycle; stay IDLE,
//   no state change.
//  DROP: anim_row is held for DROP_TICKS cycles, then decremented. After
//   DROP_TICKS cycles at row r, go to WRITE. DROP lasts DROP_TICKS*(ROWS-r)
//   cycles.
//  WRITE (1 cycle): wr_en=1, wr_row=r, wr_col=col, wr_colour=turn.
//   height[col]++, move_count++.
//  CHECK (1 cycle): sample win.
//   - win=1: OVER, winner=turn.
//   - else move_count==ROWS*COLS: OVER, draw=1.
//   - else toggle turn, return to IDLE.
//  OVER: game_over=1; terminal state. place is ignored (no reject); only reset
//   exits.
//  Timing: place accepted in cycle 0 -> WRITE in cycle 1+DROP_TICKS*(ROWS-r);
//   ready again 2 cycles later.
//  place while ready=0 is ignored silently; at most one move is in flight.
//  turn changes only in CHECK. wr_en never asserts outside WRITE.
//  Reset mid-DROP or mid-WRITE: no wr_en is emitted after the reset cycle;
//   heights and turn are cleared.
//  Reset has priority over every other event in the same cycle.
// TESTING
//  1. Reset, place col=3 (r=0) -> anim_row 5..0, 4 cycles each; wr_en at cycle
//     25 with row0/col3/colour01; turn=10 and ready=1 at cycle 27.
//  2. Six moves into col=0, then a seventh place col=0 -> reject pulse; turn,
//     heights and ready unchanged.
//  3. place col=7 -> reject; place during DROP -> ignored, no reject, no
//     second write.
//  4. win=1 in the CHECK cycle -> game_over=1, winner=current turn; later
//     place -> no response.
//  5. Fill all 42 cells with win=0 -> draw=1, winner=00, game_over=1.
//  6. Assert reset mid-DROP -> no wr_en; ready=1, turn=01, col heights=0 next
//     cycle.

Source files
------------

// File: rtl/move_sequencer.sv
// Connect-4 move sequencer: validates a column choice, animates the falling piece,
// issues one board write, samples the win checker, then toggles turn or ends the game.
module move_sequencer #(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int DROP_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       place,
  input  logic [2:0] column,
  input  logic       win,
  output logic       ready,
  output logic       reject,
  output logic [1:0] turn,
  output logic       anim_valid,
  output logic [2:0] anim_row,
  output logic [2:0] anim_col,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_colour,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
);

  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DROP, S_WRITE, S_CHECK, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [2:0]      col_q, col_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      anim_q, anim_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      turn_q, turn_d;
  logic [3:0]      height_q [COLS];
  logic [3:0]      height_d [COLS];
  logic [6:0]      count_q, count_d;
  logic            reject_q, reject_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;
  logic [3:0]      sel_h;
  logic            col_ok;

  // Fill height of the requested column; out-of-range columns read as 0 and are refused below.
  always_comb begin
    sel_h = '0;
    for (int i = 0; i < COLS; i++) begin
      if ({1'b0, column} == 4'(i)) sel_h = height_q[i];
    end
    col_ok = ({1'b0, column} < 4'(COLS)) && (sel_h < 4'(ROWS));
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    anim_d   = anim_q;
    tick_d   = tick_q;
    turn_d   = turn_q;
    height_d = height_q;
    count_d  = count_q;
    reject_d = 1'b0;
    winner_d = winner_q;
    draw_d   = draw_q;
    case (state_q)
      S_IDLE: begin
        if (place) begin
          if (col_ok) begin
            col_d   = column;
            row_d   = sel_h[2:0];
            anim_d  = 3'(ROWS - 1);
            tick_d  = '0;
            state_d = S_DROP;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (tick_q == TW'(DROP_TICKS - 1)) begin
          tick_d = '0;
          if (anim_q == row_q) state_d = S_WRITE;
          else                 anim_d  = anim_q - 3'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_WRITE: begin
        for (int i = 0; i < COLS; i++) begin
          if (col_q == 3'(i)) height_d[i] = height_q[i] + 4'd1;
        end
        count_d = count_q + 7'd1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (win) begin
          winner_d = turn_q;
          state_d  = S_OVER;
        end else if (count_q == 7'(ROWS * COLS)) begin
          draw_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_IDLE;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      anim_q   <= '0;
      tick_q   <= '0;
      turn_q   <= 2'b01;
      count_q  <= '0;
      reject_q <= 1'b0;
      winner_q <= 2'b00;
      draw_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) height_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      anim_q   <= anim_d;
      tick_q   <= tick_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      reject_q <= reject_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      for (int i = 0; i < COLS; i++) height_q[i] <= height_d[i];
    end
  end

  // Position/write fields are forced to zero outside their qualifying state.
  always_comb begin
    ready      = (state_q == S_IDLE);
    reject     = reject_q;
    turn       = turn_q;
    anim_valid = (state_q == S_DROP);
    anim_row   = anim_valid ? anim_q : 3'd0;
    anim_col   = anim_valid ? col_q  : 3'd0;
    wr_en      = (state_q == S_WRITE);
    wr_row     = wr_en ? row_q  : 3'd0;
    wr_col     = wr_en ? col_q  : 3'd0;
    wr_colour  = wr_en ? turn_q : 2'b00;
    game_over  = (state_q == S_OVER);
    winner     = winner_q;
    draw       = draw_q;
  end

endmodule
